// File: rtl/dbg_bus_master_if.sv
// ---------------------------------------------------------------------------
// dbg_bus_master_if
// Memory-controller data-port bundle driven by the debug bus master.
// Signal names are seen from the master side:
//   o_addr       32  bus address
//   o_wdata      32  write data
//   o_width       2  1=byte, 2=half, 3=word
//   o_we          1  one-cycle write strobe
//   o_read_en     1  one-cycle read strobe
//   o_zeroextend  1  zero-extend narrow reads
//   i_rdata      32  read data, valid the cycle after o_read_en
// ---------------------------------------------------------------------------
interface dbg_bus_master_if;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [1:0]  o_width;
    logic        o_we;
    logic        o_read_en;
    logic        o_zeroextend;
    logic [31:0] i_rdata;

    modport master (
        output o_addr, o_wdata, o_width, o_we, o_read_en, o_zeroextend,
        input  i_rdata
    );

    modport slave (
        input  o_addr, o_wdata, o_width, o_we, o_read_en, o_zeroextend,
        output i_rdata
    );
endinterface

// File: rtl/dbg_bus_master.sv
// ---------------------------------------------------------------------------
// dbg_bus_master
// Bridges a UART byte stream onto the memory-controller data port so a host
// can load and inspect memory while the core is held off through o_busy.
//
// Frame: command byte, 4 address bytes LSB first, then 4 write-data bytes
// LSB first for writes. Command byte: [7:4] op (1=read, 2=write),
// [3] repeat direction, [2] zeroextend, [1:0] width (0 means word).
// A write answers ACK_BYTE; a read answers the 4 read-data bytes LSB first;
// an illegal op or an inter-byte timeout answers ERR_BYTE.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_rx_data/valid     received byte and its one-cycle strobe
//   o_tx_data/valid     byte to send, held until i_tx_ready
//   bus                 memory data port (dbg_bus_master_if.master)
//   o_busy              high from command byte to last response byte
//   o_rx_dropped        one-cycle pulse for a byte arriving while not receiving
//   o_dbg_state         current FSM state encoding
//
// Handshake: a TX byte transfers in a cycle where o_tx_valid and i_tx_ready
// are both high; o_tx_valid and o_tx_data stay stable until that cycle.
//
// Optional macro DBG_AUTOINC_EN: enables op 3 ("repeat"), which reuses the
// stored address (bit [3] selects write) and advances that address by the
// access size after every bus access. Without it op 3 is illegal.
// ---------------------------------------------------------------------------
module dbg_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    dbg_bus_master_if.master bus,
    output logic             o_busy,
    output logic             o_rx_dropped,
    output logic [2:0]       o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA    = 3'd2,
        S_ACCESS  = 3'd3,
        S_WAIT_RD = 3'd4,
        S_RESP    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_cnt;
    logic        r_is_wr, w_is_wr_nxt;
    logic [1:0]  r_width, w_width_nxt;
    logic        r_zext, w_zext_nxt;
    logic [31:0] r_addr_sh, w_addr_sh_nxt;
    logic [31:0] r_wdata_sh, w_wdata_sh_nxt;
    logic [31:0] r_tmo;
    logic [31:0] r_resp;
    logic [1:0]  r_resp_idx, r_resp_last;
    logic [31:0] r_bus_addr, r_bus_wdata;
    logic [1:0]  r_bus_width;
    logic        r_bus_zext, r_we, r_read_en, r_rx_dropped;
    logic [3:0]  w_op;
    logic        w_cmd_legal, w_timeout, w_frame_byte, w_drop;
`ifdef DBG_AUTOINC_EN
    logic [31:0] r_addr_st;     // address kept for repeat commands
    logic [31:0] w_step;
`endif

    always_comb begin
        w_op         = i_rx_data[7:4];
        w_cmd_legal  = (w_op == 4'd1) || (w_op == 4'd2);
`ifdef DBG_AUTOINC_EN
        w_cmd_legal  = w_cmd_legal || (w_op == 4'd3);
        case (r_bus_width)
            2'd1:    w_step = 32'd1;
            2'd2:    w_step = 32'd2;
            default: w_step = 32'd4;
        endcase
`endif
        w_timeout    = (r_tmo == TIMEOUT_CYCLES - 1);
        w_frame_byte = i_rx_valid && (r_state == S_ADDR || r_state == S_DATA);
        w_drop       = i_rx_valid && (r_state == S_ACCESS || r_state == S_WAIT_RD ||
                                      r_state == S_RESP   || r_state == S_ERR);
    end

    // Next state plus the frame fields; the byte arriving this cycle is merged
    // here so the bus registers can load the complete frame on entry to ACCESS.
    always_comb begin
        w_state_nxt    = r_state;
        w_is_wr_nxt    = r_is_wr;
        w_width_nxt    = r_width;
        w_zext_nxt     = r_zext;
        w_addr_sh_nxt  = r_addr_sh;
        w_wdata_sh_nxt = r_wdata_sh;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    if (w_cmd_legal) begin
                        w_is_wr_nxt = (w_op == 4'd2);
                        w_width_nxt = (i_rx_data[1:0] == 2'd0) ? 2'd3 : i_rx_data[1:0];
                        w_zext_nxt  = i_rx_data[2];
                        w_state_nxt = S_ADDR;
`ifdef DBG_AUTOINC_EN
                        if (w_op == 4'd3) begin
                            w_is_wr_nxt   = i_rx_data[3];
                            w_addr_sh_nxt = r_addr_st;
                            w_state_nxt   = i_rx_data[3] ? S_DATA : S_ACCESS;
                        end
`endif
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_ADDR: begin
                if (i_rx_valid) begin
                    w_addr_sh_nxt[8*r_cnt +: 8] = i_rx_data;
                    if (r_cnt == 2'd3) w_state_nxt = r_is_wr ? S_DATA : S_ACCESS;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DATA: begin
                if (i_rx_valid) begin
                    w_wdata_sh_nxt[8*r_cnt +: 8] = i_rx_data;
                    if (r_cnt == 2'd3) w_state_nxt = S_ACCESS;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ACCESS:  w_state_nxt = r_is_wr ? S_RESP : S_WAIT_RD;
            S_WAIT_RD: w_state_nxt = S_RESP;
            S_RESP:    if (i_tx_ready && r_resp_idx == r_resp_last) w_state_nxt = S_IDLE;
            S_ERR:     if (i_tx_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_tx_valid = 1'b0;
        o_tx_data  = 8'd0;
        if (r_state == S_RESP) begin
            o_tx_valid = 1'b1;
            o_tx_data  = r_resp[8*r_resp_idx +: 8];
        end else if (r_state == S_ERR) begin
            o_tx_valid = 1'b1;
            o_tx_data  = ERR_BYTE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_is_wr      <= 1'b0;
            r_width      <= 2'd0;
            r_zext       <= 1'b0;
            r_addr_sh    <= 32'd0;
            r_wdata_sh   <= 32'd0;
            r_tmo        <= 32'd0;
            r_resp       <= 32'd0;
            r_resp_idx   <= 2'd0;
            r_resp_last  <= 2'd0;
            r_bus_addr   <= 32'd0;
            r_bus_wdata  <= 32'd0;
            r_bus_width  <= 2'd0;
            r_bus_zext   <= 1'b0;
            r_we         <= 1'b0;
            r_read_en    <= 1'b0;
            r_rx_dropped <= 1'b0;
`ifdef DBG_AUTOINC_EN
            r_addr_st    <= 32'd0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_is_wr      <= w_is_wr_nxt;
            r_width      <= w_width_nxt;
            r_zext       <= w_zext_nxt;
            r_addr_sh    <= w_addr_sh_nxt;
            r_wdata_sh   <= w_wdata_sh_nxt;
            r_rx_dropped <= w_drop;
            r_we         <= 1'b0;
            r_read_en    <= 1'b0;

            // Idle-cycle counter only runs while a frame is partially received.
            if ((r_state == S_ADDR || r_state == S_DATA) && !i_rx_valid)
                r_tmo <= r_tmo + 32'd1;
            else
                r_tmo <= 32'd0;

            // Wraps 3 -> 0, so the data phase starts at byte 0.
            if (r_state == S_IDLE)
                r_cnt <= 2'd0;
            else if (w_frame_byte)
                r_cnt <= r_cnt + 2'd1;

            if (w_state_nxt == S_ACCESS && r_state != S_ACCESS) begin
                r_bus_addr  <= w_addr_sh_nxt;
                r_bus_wdata <= w_wdata_sh_nxt;
                r_bus_width <= w_width_nxt;
                r_bus_zext  <= w_zext_nxt;
                r_we        <= w_is_wr_nxt;
                r_read_en   <= !w_is_wr_nxt;
            end

            if (r_state == S_ACCESS) begin
`ifdef DBG_AUTOINC_EN
                r_addr_st   <= r_bus_addr + w_step;
`endif
                r_resp      <= {24'd0, ACK_BYTE};
                r_resp_idx  <= 2'd0;
                r_resp_last <= 2'd0;
            end else if (r_state == S_WAIT_RD) begin
                r_resp      <= bus.i_rdata;
                r_resp_idx  <= 2'd0;
                r_resp_last <= 2'd3;
            end else if (r_state == S_RESP && i_tx_ready) begin
                r_resp_idx  <= r_resp_idx + 2'd1;
            end
        end
    end

    assign bus.o_addr       = r_bus_addr;
    assign bus.o_wdata      = r_bus_wdata;
    assign bus.o_width      = r_bus_width;
    assign bus.o_zeroextend = r_bus_zext;
    assign bus.o_we         = r_we;
    assign bus.o_read_en    = r_read_en;
    assign o_busy           = (r_state != S_IDLE);
    assign o_rx_dropped     = r_rx_dropped;
    assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_dbg_bus_master.sv
// ---------------------------------------------------------------------------
// tb_dbg_bus_master
// Randomised and directed frames against a transaction-level model. Each
// command pushes its expected bus access and TX bytes into queues; separate
// monitors pop and compare whenever the DUT strobes the bus or hands off a
// TX byte. Memory read data is a fixed function of the address.
// ---------------------------------------------------------------------------
module tb_dbg_bus_master;
    localparam int unsigned TMO = 40;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic        zext;
    } bus_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        rx_dropped;
    logic [2:0]  dbg_state;

    dbg_bus_master_if bus_if ();

    dbg_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .bus          (bus_if),
        .o_busy       (busy),
        .o_rx_dropped (rx_dropped),
        .o_dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          drop_seen = 0;
    int          drop_exp = 0;
    logic [7:0]  exp_tx_q[$];
    bus_exp_t    exp_bus_q[$];
    logic [31:0] model_addr = 32'd0;
    logic        force_low = 1'b0;
    logic        rd_pending = 1'b0;
    logic [31:0] rd_addr = 32'd0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h4000_0013) return 32'h0000_00FF;
        return (a * 32'h9E37_79B1) + 32'h0123_4567;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- bus slave: rdata valid the cycle after o_read_en ------
    always @(posedge clk) begin
        #1;
        if (rd_pending) bus_if.i_rdata = mem_val(rd_addr);
        else            bus_if.i_rdata = $urandom;
        rd_pending = bus_if.o_read_en;
        rd_addr    = bus_if.o_addr;
    end

    // ---------------- TX ready generator ------------------------------------
    always @(posedge clk) begin
        #1;
        tx_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // ---------------- monitors ----------------------------------------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tx_valid && tx_ready) begin
            if (exp_tx_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
            end else begin
                check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        bus_exp_t e;
        if (rst_n === 1'b1 && (bus_if.o_we || bus_if.o_read_en)) begin
            if (exp_bus_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL bus_unexpected: got we=%b re=%b addr=%h expected no strobe",
                         bus_if.o_we, bus_if.o_read_en, bus_if.o_addr);
            end else begin
                e = exp_bus_q.pop_front();
                check("bus_kind",  {30'd0, bus_if.o_we, bus_if.o_read_en}, {30'd0, e.is_wr, !e.is_wr});
                check("bus_addr",  bus_if.o_addr, e.addr);
                check("bus_width", {30'd0, bus_if.o_width}, {30'd0, e.width});
                check("bus_zext",  {31'd0, bus_if.o_zeroextend}, {31'd0, e.zext});
                if (e.is_wr) check("bus_wdata", bus_if.o_wdata, e.wdata);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rx_dropped) drop_seen++;
    end

    // ---------------- driver tasks (called at posedge + 1) ------------------
    task automatic drive_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy || exp_tx_q.size() != 0 || exp_bus_q.size() != 0) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        n_vec++;
        if (k >= 400) begin
            n_err++;
            $display("FAIL %s: got busy=%b tx_left=%0d bus_left=%0d expected idle",
                     name, busy, exp_tx_q.size(), exp_bus_q.size());
            exp_tx_q.delete();
            exp_bus_q.delete();
        end
    endtask

    // Model: pushes expectations, then sends the frame.
    task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] addr,
                           input logic [31:0] data, input int gap_max);
        bus_exp_t    e;
        logic [3:0]  op;
        logic        legal;
        logic        send_addr;
        logic [31:0] a;
        op        = cmd[7:4];
        legal     = (op == 4'd1) || (op == 4'd2);
        send_addr = 1'b1;
        a         = addr;
        e.is_wr   = (op == 4'd2);
`ifdef DBG_AUTOINC_EN
        if (op == 4'd3) begin
            legal     = 1'b1;
            send_addr = 1'b0;
            a         = model_addr;
            e.is_wr   = cmd[3];
        end
`endif
        if (!legal) begin
            exp_tx_q.push_back(8'hEE);
            drive_byte(cmd, 0);
            return;
        end
        e.addr  = a;
        e.wdata = data;
        e.width = (cmd[1:0] == 2'd0) ? 2'd3 : cmd[1:0];
        e.zext  = cmd[2];
        exp_bus_q.push_back(e);
        if (e.is_wr) begin
            exp_tx_q.push_back(8'hA5);
        end else begin
            for (int i = 0; i < 4; i++) exp_tx_q.push_back(8'(mem_val(a) >> (8 * i)));
        end
`ifdef DBG_AUTOINC_EN
        model_addr = a + ((e.width == 2'd1) ? 32'd1 : (e.width == 2'd2) ? 32'd2 : 32'd4);
`endif
        drive_byte(cmd, $urandom_range(0, gap_max));
        if (send_addr)
            for (int i = 0; i < 4; i++) drive_byte(8'(addr >> (8 * i)), $urandom_range(0, gap_max));
        if (e.is_wr)
            for (int i = 0; i < 4; i++) drive_byte(8'(data >> (8 * i)), $urandom_range(0, gap_max));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
        check({tag, "_tx_data"},  {24'd0, tx_data}, 32'd0);
        check({tag, "_busy"},     {31'd0, busy}, 32'd0);
        check({tag, "_dropped"},  {31'd0, rx_dropped}, 32'd0);
        check({tag, "_state"},    {29'd0, dbg_state}, 32'd0);
        check({tag, "_we_re"},    {30'd0, bus_if.o_we, bus_if.o_read_en}, 32'd0);
        check({tag, "_addr"},     bus_if.o_addr, 32'd0);
        check({tag, "_wdata"},    bus_if.o_wdata, 32'd0);
        check({tag, "_width"},    {30'd0, bus_if.o_width}, 32'd0);
        check({tag, "_zext"},     {31'd0, bus_if.o_zeroextend}, 32'd0);
    endtask

    // ---------------- main sequence ------------------------------------------
    initial begin
        int k;
        logic [3:0] op;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write and read
        run_cmd(8'h23, 32'h4000_0010, 32'hDEAD_BEEF, 0);
        wait_idle("write_basic");

        // Read with TX stalled, plus a byte strobed during the response
        force_low = 1'b1;
        run_cmd(8'h11, 32'h4000_0013, 32'd0, 1);
        k = 0;
        while (!tx_valid && k < 50) begin @(posedge clk); #1; k++; end
        check("resp_reached", {31'd0, tx_valid}, 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        drop_exp++;
        drive_byte(8'h23, 1);
        force_low = 1'b0;
        wait_idle("read_stall");
        check("dropped_count", drop_seen, drop_exp);

        // Illegal command
        run_cmd(8'h7F, 32'd0, 32'd0, 0);
        wait_idle("illegal");
        check("illegal_busy", {31'd0, busy}, 32'd0);

        // Timeout in the address phase, then a normal frame
        exp_tx_q.push_back(8'hEE);
        drive_byte(8'h23, 0);
        drive_byte(8'h10, 0);
        drive_byte(8'h00, 0);
        repeat (TMO + 10) begin @(posedge clk); #1; end
        wait_idle("timeout");
        run_cmd(8'h12, 32'h0000_1002, 32'd0, 2);
        wait_idle("after_timeout");

        // Repeat command (serviced or rejected depending on build)
        run_cmd(8'h23, 32'h2000_0000, 32'h1122_3344, 0);
        wait_idle("autoinc_base");
        run_cmd(8'h3B, 32'd0, 32'h5566_7788, 0);
        wait_idle("autoinc_repeat");

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 9);
            if (k < 4)      op = 4'd1;
            else if (k < 8) op = 4'd2;
            else if (k < 9) op = 4'd3;
            else            op = 4'($urandom_range(0, 15));
            run_cmd({op, 4'($urandom)}, $urandom, $urandom, 3);
            wait_idle("random");
        end
        check("dropped_total", drop_seen, drop_exp);

        // Reset in the middle of a response
        force_low = 1'b1;
        run_cmd(8'h13, 32'h0000_0040, 32'd0, 0);
        k = 0;
        while (!tx_valid && k < 50) begin @(posedge clk); #1; k++; end
        check("resp_before_reset", {31'd0, tx_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midreset");
        exp_tx_q.delete();
        model_addr = 32'd0;
        rst_n     = 1'b1;
        force_low = 1'b0;
        @(posedge clk); #1;
        run_cmd(8'h22, 32'h0000_2000, 32'hCAFE_F00D, 1);
        wait_idle("after_reset");

        check("tx_queue_empty",  exp_tx_q.size(), 32'd0);
        check("bus_queue_empty", exp_bus_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end
endmodule
